// File: rtl/multicycle_controller_if.sv
// Control bus between the multi-cycle MIPS controller and its datapath.
// The controller drives the master side; the datapath (or a bench) drives the slave side.
interface multicycle_controller_if #(
    parameter int CNT_W = 32
);
    logic [5:0]       opcode;
    logic             mem_ready;
    logic             pc_write;
    logic             branch_eq;
    logic             branch_ne;
    logic             i_or_d;
    logic             mem_read;
    logic             mem_write;
    logic             ir_write;
    logic             mem_to_reg;
    logic             reg_dst;
    logic             reg_write;
    logic             alu_src_a;
    logic [1:0]       alu_src_b;
    logic [3:0]       alu_op;
    logic [1:0]       pc_source;
    logic             illegal_op;
    logic [3:0]       state;
    logic [CNT_W-1:0] retired;

    modport master (
        input  opcode, mem_ready,
        output pc_write, branch_eq, branch_ne, i_or_d, mem_read, mem_write,
               ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b,
               alu_op, pc_source, illegal_op, state, retired
    );

    modport slave (
        output opcode, mem_ready,
        input  pc_write, branch_eq, branch_ne, i_or_d, mem_read, mem_write,
               ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b,
               alu_op, pc_source, illegal_op, state, retired
    );
endinterface

// File: rtl/multicycle_controller.sv
// Moore-style sequencer for a multi-cycle MIPS datapath with one shared memory.
// Control outputs are decoded from the registered state; only the fetch
// handshake (ir_write/pc_write), the decode-time illegal flag and the branch
// flavour look at the current inputs, because they must act in that same cycle.
// A retired-instruction counter tracks completed instructions for debug.
module multicycle_controller #(
    parameter logic [3:0] ALU_ADD   = 4'b0010,
    parameter logic [3:0] ALU_SUB   = 4'b0110,
    parameter logic [3:0] ALU_FUNCT = 4'b1111,
    parameter int         CNT_W     = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    multicycle_controller_if.master  bus
);

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_BNE  = 6'h05;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_J    = 6'h02;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    state_t           state_r;
    state_t           next_s;
    logic             retire_s;
    logic [CNT_W-1:0] retired_r;

    // True for every opcode this controller knows how to sequence.
    function automatic logic is_legal(input logic [5:0] op);
        logic ok;
        case (op)
            OP_R, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_J: ok = 1'b1;
            default:                                           ok = 1'b0;
        endcase
        return ok;
    endfunction

    // State register: synchronous reset always returns to instruction fetch.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= S_FETCH;
        end else begin
            state_r <= next_s;
        end
    end

    // Retired-instruction counter: wraps freely, cleared by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            retired_r <= {CNT_W{1'b0}};
        end else if (retire_s) begin
            retired_r <= retired_r + CNT_W'(1);
        end else begin
            retired_r <= retired_r;
        end
    end

    // Next-state logic; retire_s flags the final cycle of a completed instruction.
    always_comb begin
        next_s   = S_FETCH;
        retire_s = 1'b0;
        case (state_r)
            S_FETCH: begin
                if (bus.mem_ready) begin
                    next_s = S_DECODE;
                end else begin
                    next_s = S_FETCH;
                end
            end
            S_DECODE: begin
                case (bus.opcode)
                    OP_LW, OP_SW:   next_s = S_MEMADR;
                    OP_R:           next_s = S_EXEC;
                    OP_BEQ, OP_BNE: next_s = S_BRANCH;
                    OP_ADDI:        next_s = S_ADDIEX;
                    OP_J:           next_s = S_JUMP;
                    default:        next_s = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                // The instruction register is stable, so re-reading the opcode is safe.
                case (bus.opcode)
                    OP_LW:   next_s = S_MEMRD;
                    OP_SW:   next_s = S_MEMWR;
                    default: next_s = S_FETCH;
                endcase
            end
            S_MEMRD: begin
                if (bus.mem_ready) begin
                    next_s = S_MEMWB;
                end else begin
                    next_s = S_MEMRD;
                end
            end
            S_MEMWB: begin
                next_s   = S_FETCH;
                retire_s = 1'b1;
            end
            S_MEMWR: begin
                if (bus.mem_ready) begin
                    next_s   = S_FETCH;
                    retire_s = 1'b1;
                end else begin
                    next_s   = S_MEMWR;
                    retire_s = 1'b0;
                end
            end
            S_EXEC:   next_s = S_ALUWB;
            S_ALUWB: begin
                next_s   = S_FETCH;
                retire_s = 1'b1;
            end
            S_BRANCH: begin
                next_s   = S_FETCH;
                retire_s = 1'b1;
            end
            S_ADDIEX: next_s = S_ADDIWB;
            S_ADDIWB: begin
                next_s   = S_FETCH;
                retire_s = 1'b1;
            end
            S_JUMP: begin
                next_s   = S_FETCH;
                retire_s = 1'b1;
            end
            default: begin
                next_s   = S_FETCH;
                retire_s = 1'b0;
            end
        endcase
    end

    // Output decode: every control defaults low and is raised only where needed.
    always_comb begin
        bus.pc_write   = 1'b0;
        bus.branch_eq  = 1'b0;
        bus.branch_ne  = 1'b0;
        bus.i_or_d     = 1'b0;
        bus.mem_read   = 1'b0;
        bus.mem_write  = 1'b0;
        bus.ir_write   = 1'b0;
        bus.mem_to_reg = 1'b0;
        bus.reg_dst    = 1'b0;
        bus.reg_write  = 1'b0;
        bus.alu_src_a  = 1'b0;
        bus.alu_src_b  = 2'd0;
        bus.alu_op     = 4'b0000;
        bus.pc_source  = 2'd0;
        bus.illegal_op = 1'b0;
        case (state_r)
            S_FETCH: begin
                bus.mem_read  = 1'b1;
                bus.alu_src_b = 2'd1;
                bus.alu_op    = ALU_ADD;
                // IR and PC load together only when the instruction word arrives.
                if (bus.mem_ready) begin
                    bus.ir_write = 1'b1;
                    bus.pc_write = 1'b1;
                end else begin
                    bus.ir_write = 1'b0;
                    bus.pc_write = 1'b0;
                end
            end
            S_DECODE: begin
                bus.alu_src_b = 2'd3;
                bus.alu_op    = ALU_ADD;
                if (is_legal(bus.opcode)) begin
                    bus.illegal_op = 1'b0;
                end else begin
                    bus.illegal_op = 1'b1;
                end
            end
            S_MEMADR, S_ADDIEX: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'd2;
                bus.alu_op    = ALU_ADD;
            end
            S_MEMRD: begin
                bus.mem_read = 1'b1;
                bus.i_or_d   = 1'b1;
            end
            S_MEMWB: begin
                bus.reg_write  = 1'b1;
                bus.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                bus.mem_write = 1'b1;
                bus.i_or_d    = 1'b1;
            end
            S_EXEC: begin
                bus.alu_src_a = 1'b1;
                bus.alu_op    = ALU_FUNCT;
            end
            S_ALUWB: begin
                bus.reg_write = 1'b1;
                bus.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                bus.alu_src_a = 1'b1;
                bus.alu_op    = ALU_SUB;
                bus.pc_source = 2'd1;
                bus.branch_eq = (bus.opcode == OP_BEQ);
                bus.branch_ne = (bus.opcode == OP_BNE);
            end
            S_ADDIWB: begin
                bus.reg_write = 1'b1;
            end
            S_JUMP: begin
                bus.pc_write  = 1'b1;
                bus.pc_source = 2'd2;
            end
            default: begin
                bus.mem_read = 1'b0;
            end
        endcase
    end

    assign bus.state   = state_r;
    assign bus.retired = retired_r;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: walks each instruction class
// through the FSM with hand-written per-cycle expected states and control words.
module tb_multicycle_controller;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    logic [31:0] exp_ret;

    multicycle_controller_if #(.CNT_W(32)) bus ();

    multicycle_controller #(.CNT_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Control word: pc_write, branch_eq, branch_ne, i_or_d, mem_read, mem_write,
    // ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source, illegal_op
    logic [19:0] ctl;
    assign ctl = {bus.pc_write, bus.branch_eq, bus.branch_ne, bus.i_or_d, bus.mem_read,
                  bus.mem_write, bus.ir_write, bus.mem_to_reg, bus.reg_dst, bus.reg_write,
                  bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.pc_source, bus.illegal_op};

    localparam logic [19:0] C_FW     = {1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd1,4'b0010,2'd0,1'b0};
    localparam logic [19:0] C_FR     = {1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'd1,4'b0010,2'd0,1'b0};
    localparam logic [19:0] C_DEC    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd3,4'b0010,2'd0,1'b0};
    localparam logic [19:0] C_DECILL = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd3,4'b0010,2'd0,1'b1};
    localparam logic [19:0] C_MEMADR = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'd2,4'b0010,2'd0,1'b0};
    localparam logic [19:0] C_MEMRD  = {1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,4'b0000,2'd0,1'b0};
    localparam logic [19:0] C_MEMWB  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,2'd0,4'b0000,2'd0,1'b0};
    localparam logic [19:0] C_MEMWR  = {1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,4'b0000,2'd0,1'b0};
    localparam logic [19:0] C_EXEC   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'd0,4'b1111,2'd0,1'b0};
    localparam logic [19:0] C_ALUWB  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,2'd0,4'b0000,2'd0,1'b0};
    localparam logic [19:0] C_BREQ   = {1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'd0,4'b0110,2'd1,1'b0};
    localparam logic [19:0] C_BRNE   = {1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'd0,4'b0110,2'd1,1'b0};
    localparam logic [19:0] C_ADDIWB = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'd0,4'b0000,2'd0,1'b0};
    localparam logic [19:0] C_JUMP   = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,4'b0000,2'd2,1'b0};

    // Apply inputs for the current cycle and let combinational outputs settle.
    task automatic drive(input logic [5:0] op, input logic rdy);
        bus.opcode    = op;
        bus.mem_ready = rdy;
        #1;
    endtask

    // Advance one clock and step just past the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(6'h00, 1'b0);
        tick();
        tick();
        reset = 1'b0;
        drive(6'h00, 1'b0);
        exp_ret = 32'd0;
        checks++; if (bus.state !== 4'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", bus.state); end
        checks++; if (bus.retired !== 32'd0) begin errors++; $display("FAIL reset_retired got %0d exp 0", bus.retired); end
        checks++; if (ctl !== C_FW) begin errors++; $display("FAIL reset_ctl got %h exp %h", ctl, C_FW); end
    endtask

    task automatic test_rtype();
        logic [3:0]  st [4] = '{4'd0, 4'd1, 4'd6, 4'd7};
        logic [19:0] cw [4] = '{C_FR, C_DEC, C_EXEC, C_ALUWB};
        for (int i = 0; i < 4; i++) begin
            drive(6'h00, 1'b1);
            checks++; if (bus.state !== st[i]) begin errors++; $display("FAIL rtype_state c%0d got %0d exp %0d", i, bus.state, st[i]); end
            checks++; if (ctl !== cw[i]) begin errors++; $display("FAIL rtype_ctl c%0d got %h exp %h", i, ctl, cw[i]); end
            tick();
        end
        drive(6'h00, 1'b0);
        exp_ret = exp_ret + 32'd1;
        checks++; if (bus.state !== 4'd0) begin errors++; $display("FAIL rtype_end_state got %0d exp 0", bus.state); end
        checks++; if (bus.retired !== exp_ret) begin errors++; $display("FAIL rtype_retired got %0d exp %0d", bus.retired, exp_ret); end
    endtask

    task automatic test_lw_wait();
        logic [3:0]  st [10] = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd3, 4'd4};
        logic        rd [10] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [19:0] cw [10] = '{C_FW, C_FW, C_FR, C_DEC, C_MEMADR, C_MEMRD, C_MEMRD, C_MEMRD, C_MEMRD, C_MEMWB};
        int ir_cnt = 0;
        int wb_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            drive(6'h23, rd[i]);
            if (bus.ir_write === 1'b1) ir_cnt++;
            if (bus.reg_write === 1'b1 && bus.mem_to_reg === 1'b1) wb_cnt++;
            checks++; if (bus.state !== st[i]) begin errors++; $display("FAIL lw_state c%0d got %0d exp %0d", i, bus.state, st[i]); end
            checks++; if (ctl !== cw[i]) begin errors++; $display("FAIL lw_ctl c%0d got %h exp %h", i, ctl, cw[i]); end
            tick();
        end
        drive(6'h23, 1'b0);
        exp_ret = exp_ret + 32'd1;
        checks++; if (bus.state !== 4'd0) begin errors++; $display("FAIL lw_end_state got %0d exp 0", bus.state); end
        checks++; if (bus.retired !== exp_ret) begin errors++; $display("FAIL lw_retired got %0d exp %0d", bus.retired, exp_ret); end
        checks++; if (ir_cnt !== 1) begin errors++; $display("FAIL lw_ir_pulses got %0d exp 1", ir_cnt); end
        checks++; if (wb_cnt !== 1) begin errors++; $display("FAIL lw_mem_wb got %0d exp 1", wb_cnt); end
    endtask

    task automatic test_sw();
        logic [3:0]  st [4] = '{4'd0, 4'd1, 4'd2, 4'd5};
        logic [19:0] cw [4] = '{C_FR, C_DEC, C_MEMADR, C_MEMWR};
        int mw_cnt = 0;
        int rw_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            drive(6'h2B, 1'b1);
            if (bus.mem_write === 1'b1) mw_cnt++;
            if (bus.reg_write === 1'b1) rw_cnt++;
            checks++; if (bus.state !== st[i]) begin errors++; $display("FAIL sw_state c%0d got %0d exp %0d", i, bus.state, st[i]); end
            checks++; if (ctl !== cw[i]) begin errors++; $display("FAIL sw_ctl c%0d got %h exp %h", i, ctl, cw[i]); end
            tick();
        end
        drive(6'h2B, 1'b0);
        exp_ret = exp_ret + 32'd1;
        checks++; if (bus.state !== 4'd0) begin errors++; $display("FAIL sw_end_state got %0d exp 0", bus.state); end
        checks++; if (bus.retired !== exp_ret) begin errors++; $display("FAIL sw_retired got %0d exp %0d", bus.retired, exp_ret); end
        checks++; if (mw_cnt !== 1) begin errors++; $display("FAIL sw_mem_write_cycles got %0d exp 1", mw_cnt); end
        checks++; if (rw_cnt !== 0) begin errors++; $display("FAIL sw_reg_write_cycles got %0d exp 0", rw_cnt); end
    endtask

    task automatic test_back_to_back();
        logic [5:0]  op [6] = '{6'h04, 6'h04, 6'h04, 6'h05, 6'h05, 6'h05};
        logic [3:0]  st [6] = '{4'd0, 4'd1, 4'd8, 4'd0, 4'd1, 4'd8};
        logic [19:0] cw [6] = '{C_FR, C_DEC, C_BREQ, C_FR, C_DEC, C_BRNE};
        for (int i = 0; i < 6; i++) begin
            drive(op[i], 1'b1);
            checks++; if (bus.state !== st[i]) begin errors++; $display("FAIL br_state c%0d got %0d exp %0d", i, bus.state, st[i]); end
            checks++; if (ctl !== cw[i]) begin errors++; $display("FAIL br_ctl c%0d got %h exp %h", i, ctl, cw[i]); end
            tick();
        end
        drive(6'h05, 1'b0);
        exp_ret = exp_ret + 32'd2;
        checks++; if (bus.retired !== exp_ret) begin errors++; $display("FAIL br_retired got %0d exp %0d", bus.retired, exp_ret); end
    endtask

    task automatic test_illegal_jump();
        logic [5:0]  op [5] = '{6'h3F, 6'h3F, 6'h02, 6'h02, 6'h02};
        logic [3:0]  st [5] = '{4'd0, 4'd1, 4'd0, 4'd1, 4'd11};
        logic [19:0] cw [5] = '{C_FR, C_DECILL, C_FR, C_DEC, C_JUMP};
        for (int i = 0; i < 5; i++) begin
            drive(op[i], 1'b1);
            checks++; if (bus.state !== st[i]) begin errors++; $display("FAIL illj_state c%0d got %0d exp %0d", i, bus.state, st[i]); end
            checks++; if (ctl !== cw[i]) begin errors++; $display("FAIL illj_ctl c%0d got %h exp %h", i, ctl, cw[i]); end
            if (i == 2) begin
                checks++; if (bus.retired !== exp_ret) begin errors++; $display("FAIL illegal_retired got %0d exp %0d", bus.retired, exp_ret); end
            end
            tick();
        end
        drive(6'h02, 1'b0);
        exp_ret = exp_ret + 32'd1;
        checks++; if (bus.retired !== exp_ret) begin errors++; $display("FAIL jump_retired got %0d exp %0d", bus.retired, exp_ret); end
    endtask

    task automatic test_addi();
        logic [3:0]  st [4] = '{4'd0, 4'd1, 4'd9, 4'd10};
        logic [19:0] cw [4] = '{C_FR, C_DEC, C_MEMADR, C_ADDIWB};
        for (int i = 0; i < 4; i++) begin
            drive(6'h08, 1'b1);
            checks++; if (bus.state !== st[i]) begin errors++; $display("FAIL addi_state c%0d got %0d exp %0d", i, bus.state, st[i]); end
            checks++; if (ctl !== cw[i]) begin errors++; $display("FAIL addi_ctl c%0d got %h exp %h", i, ctl, cw[i]); end
            tick();
        end
        drive(6'h08, 1'b0);
        exp_ret = exp_ret + 32'd1;
        checks++; if (bus.retired !== exp_ret) begin errors++; $display("FAIL addi_retired got %0d exp %0d", bus.retired, exp_ret); end
    endtask

    task automatic test_reset_midwr();
        logic [3:0]  st [4] = '{4'd0, 4'd1, 4'd2, 4'd5};
        logic        rd [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        logic [19:0] cw [4] = '{C_FR, C_DEC, C_MEMADR, C_MEMWR};
        for (int i = 0; i < 4; i++) begin
            drive(6'h2B, rd[i]);
            checks++; if (bus.state !== st[i]) begin errors++; $display("FAIL rstwr_state c%0d got %0d exp %0d", i, bus.state, st[i]); end
            checks++; if (ctl !== cw[i]) begin errors++; $display("FAIL rstwr_ctl c%0d got %h exp %h", i, ctl, cw[i]); end
            tick();
        end
        reset = 1'b1;
        drive(6'h2B, 1'b0);
        tick();
        reset = 1'b0;
        drive(6'h2B, 1'b0);
        exp_ret = 32'd0;
        checks++; if (bus.state !== 4'd0) begin errors++; $display("FAIL rstwr_after_state got %0d exp 0", bus.state); end
        checks++; if (bus.mem_write !== 1'b0) begin errors++; $display("FAIL rstwr_mem_write got %0b exp 0", bus.mem_write); end
        checks++; if (bus.retired !== 32'd0) begin errors++; $display("FAIL rstwr_retired got %0d exp 0", bus.retired); end
        checks++; if (ctl !== C_FW) begin errors++; $display("FAIL rstwr_ctl got %h exp %h", ctl, C_FW); end
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        exp_ret       = 32'd0;
        reset         = 1'b1;
        bus.opcode    = 6'h00;
        bus.mem_ready = 1'b0;
        test_reset();
        test_rtype();
        test_lw_wait();
        test_sw();
        test_back_to_back();
        test_illegal_jump();
        test_addi();
        test_reset_midwr();
        test_rtype();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
